// File: rtl/mem_pkg.sv
// Shared data-RAM access encodings and the mem_access_unit state type.
// Used by the RAM model, the instruction decoder and the load/store unit.
package mem_pkg;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;
  localparam logic [1:0] MEM_ILL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_SPLIT  = 2'd2,
    ST_RESP   = 2'd3
  } mau_state_e;

  // Illegal size maps to 4 bytes; the caller flags it as an error anyway.
  function automatic logic [2:0] size_nbytes(input logic [1:0] size);
    case (size)
      MEM_BYTE: size_nbytes = 3'd1;
      MEM_HALF: size_nbytes = 3'd2;
      default:  size_nbytes = 3'd4;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_BYTE: is_aligned = 1'b1;
      MEM_HALF: is_aligned = ~addr_lo[0];
      default:  is_aligned = (addr_lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data extension: sign/zero-extends a right-justified byte or half to 32 bits.
// Purely combinational; shared with the single-cycle datapath load path.
module load_extend
  import mem_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_raw,
  output logic [31:0] o_ext
);

  always_comb begin
    o_ext = i_raw;
    case (i_size)
      MEM_BYTE: o_ext = i_unsigned ? {24'b0, i_raw[7:0]}
                                   : {{24{i_raw[7]}}, i_raw[7:0]};
      MEM_HALF: o_ext = i_unsigned ? {16'b0, i_raw[15:0]}
                                   : {{16{i_raw[15]}}, i_raw[15:0]};
      default:  o_ext = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the data RAM: aligned = 1 RAM cycle, misaligned = byte splits.
// Response 2 cycles after handshake (aligned), nbytes+1 (split), 1 (error); req_ready only in IDLE.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [1:0]  mem_ctrl,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  mau_state_e  r_state;
  mau_state_e  w_state_nxt;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_k;
  logic [31:0] r_asm;

  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic [32:0] w_req_end;
  logic        w_req_err;
  logic [1:0]  w_last_k;
  logic [31:0] w_asm_nxt;
  logic [31:0] w_ext_raw;
  logic [31:0] w_ext;
  logic        w_rsp_fire;
  logic [31:0] w_rsp_rdata_nxt;
  logic        w_rsp_err_nxt;

  // Last byte address evaluated at 33 bits so addresses near 2^32 cannot wrap into range.
  assign w_req_end = {1'b0, req_addr} + {30'b0, size_nbytes(req_size)} - 33'd1;
  assign w_req_err = (req_size == MEM_ILL) || (w_req_end >= 33'(MEM_BYTES));
  assign w_last_k  = 2'(size_nbytes(r_size) - 3'd1);

  load_extend u_load_extend (
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_raw      (w_ext_raw),
    .o_ext      (w_ext)
  );

  always_comb begin
    w_state_nxt     = r_state;
    mem_we          = 1'b0;
    mem_ctrl        = MEM_BYTE;
    mem_address     = 32'd0;
    mem_data_in     = 32'd0;
    w_asm_nxt       = r_asm;
    w_ext_raw       = mem_data_out;
    w_rsp_fire      = 1'b0;
    w_rsp_rdata_nxt = 32'd0;
    w_rsp_err_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_req_err) begin
            w_state_nxt   = ST_RESP;
            w_rsp_fire    = 1'b1;
            w_rsp_err_nxt = 1'b1;
          end else if (is_aligned(req_size, req_addr[1:0])) begin
            w_state_nxt = ST_ACCESS;
          end else begin
            w_state_nxt = ST_SPLIT;
          end
        end
      end

      ST_ACCESS: begin
        mem_we          = r_we;
        mem_ctrl        = r_size;
        mem_address     = r_addr;
        mem_data_in     = r_wdata;
        w_ext_raw       = mem_data_out;
        w_state_nxt     = ST_RESP;
        w_rsp_fire      = 1'b1;
        w_rsp_rdata_nxt = r_we ? 32'd0 : w_ext;
      end

      ST_SPLIT: begin
        mem_we      = r_we;
        mem_ctrl    = MEM_BYTE;
        mem_address = r_addr + {30'b0, r_k};
        mem_data_in = {24'b0, 8'(r_wdata >> {r_k, 3'b000})};
        w_asm_nxt[{r_k, 3'b000} +: 8] = mem_data_out[7:0];
        // Extension sees the assembled word including the byte read this cycle.
        w_ext_raw   = w_asm_nxt;
        if (r_k == w_last_k) begin
          w_state_nxt     = ST_RESP;
          w_rsp_fire      = 1'b1;
          w_rsp_rdata_nxt = r_we ? 32'd0 : w_ext;
        end
      end

      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_size      <= MEM_BYTE;
      r_unsigned  <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_k         <= 2'd0;
      r_asm       <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= w_rsp_fire;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      if (r_state == ST_IDLE && req_valid) begin
        r_we       <= req_we;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_addr     <= req_addr;
        r_wdata    <= req_wdata;
        r_k        <= 2'd0;
        r_asm      <= 32'd0;
      end
      if (r_state == ST_SPLIT) begin
        r_k   <= r_k + 2'd1;
        r_asm <= w_asm_nxt;
      end
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-array RAM model on the mem_* port.
module tb_mem_access_unit;

  localparam int MEM_BYTES = 4096;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [1:0]  mem_ctrl;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  int n_checks;
  int n_errors;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_ctrl     (mem_ctrl),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational right-justified zero-filled read, byte-lane write on clk.
  logic [7:0]  ram [0:MEM_BYTES-1];
  logic [11:0] a0, a1, a2, a3;
  assign a0 = mem_address[11:0];
  assign a1 = a0 + 12'd1;
  assign a2 = a0 + 12'd2;
  assign a3 = a0 + 12'd3;

  always_comb begin
    mem_data_out = 32'd0;
    case (mem_ctrl)
      2'd0:    mem_data_out = {24'd0, ram[a0]};
      2'd1:    mem_data_out = {16'd0, ram[a1], ram[a0]};
      default: mem_data_out = {ram[a3], ram[a2], ram[a1], ram[a0]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      ram[a0] <= mem_data_in[7:0];
      if (mem_ctrl != 2'd0) ram[a1] <= mem_data_in[15:8];
      if (mem_ctrl == 2'd2) begin
        ram[a2] <= mem_data_in[23:16];
        ram[a3] <= mem_data_in[31:24];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Per-cycle trace of the mem_* port for the most recent request (index = cycles after handshake).
  logic        log_we   [0:31];
  logic [1:0]  log_ctrl [0:31];
  logic [31:0] log_addr [0:31];
  logic [31:0] log_din  [0:31];

  // Called at posedge+1 with the DUT idle; returns at posedge+1 the cycle after the response.
  task automatic do_req(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int wecnt);
    int ready_hi;
    ready_hi = 0;
    wecnt    = 0;
    rdata    = 32'hx;
    err      = 1'bx;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    chk({name, "_ready_idle"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      log_we[lat] = mem_we; log_ctrl[lat] = mem_ctrl;
      log_addr[lat] = mem_address; log_din[lat] = mem_data_in;
      if (mem_we) wecnt++;
      if (req_ready) ready_hi++;
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) chk({name, "_timeout"}, 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    if (mem_we) wecnt++;
    if (req_ready) ready_hi++;
    chk({name, "_ready_busy"}, 32'(ready_hi), 32'd0);
    @(posedge clk); #1;
    chk({name, "_rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk({name, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_req_ready"},   32'(req_ready), 32'd1);
    chk({name, "_rsp_valid"},   32'(rsp_valid), 32'd0);
    chk({name, "_rsp_rdata"},   rsp_rdata,      32'd0);
    chk({name, "_rsp_err"},     32'(rsp_err),   32'd0);
    chk({name, "_mem_we"},      32'(mem_we),    32'd0);
    chk({name, "_mem_ctrl"},    32'(mem_ctrl),  32'd0);
    chk({name, "_mem_address"}, mem_address,    32'd0);
    chk({name, "_mem_data_in"}, mem_data_in,    32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_we;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input int exp_we);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_we = exp_we;
    return v;
  endfunction

  vec_t vecs [15];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wec;
    int          rsp_seen;
    logic [7:0]  exp_bytes [4];
    string       nm;

    for (int i = 0; i < MEM_BYTES; i++) ram[i] = 8'h00;
    n_checks = 0; n_errors = 0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;

    //           we    size  uns   addr          wdata         rdata         err   lat we
    vecs[0]  = mk(1'b1, 2'd2, 1'b0, 32'd4,        32'h12345678, 32'h00000000, 1'b0, 2, 1);
    vecs[1]  = mk(1'b0, 2'd2, 1'b0, 32'd4,        32'h0,        32'h12345678, 1'b0, 2, 0);
    vecs[2]  = mk(1'b0, 2'd0, 1'b0, 32'd7,        32'h0,        32'h00000012, 1'b0, 2, 0);
    vecs[3]  = mk(1'b0, 2'd0, 1'b0, 32'd4,        32'h0,        32'h00000078, 1'b0, 2, 0);
    vecs[4]  = mk(1'b1, 2'd0, 1'b0, 32'd8,        32'h00000080, 32'h00000000, 1'b0, 2, 1);
    vecs[5]  = mk(1'b0, 2'd0, 1'b0, 32'd8,        32'h0,        32'hFFFFFF80, 1'b0, 2, 0);
    vecs[6]  = mk(1'b0, 2'd0, 1'b1, 32'd8,        32'h0,        32'h00000080, 1'b0, 2, 0);
    vecs[7]  = mk(1'b0, 2'd1, 1'b0, 32'd6,        32'h0,        32'h00001234, 1'b0, 2, 0);
    vecs[8]  = mk(1'b0, 2'd1, 1'b1, 32'd4,        32'h0,        32'h00005678, 1'b0, 2, 0);
    vecs[9]  = mk(1'b1, 2'd3, 1'b0, 32'd0,        32'hCAFEF00D, 32'h00000000, 1'b1, 1, 0);
    vecs[10] = mk(1'b0, 2'd2, 1'b0, 32'd4094,     32'h0,        32'h00000000, 1'b1, 1, 0);
    vecs[11] = mk(1'b0, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h0,        32'h00000000, 1'b1, 1, 0);
    vecs[12] = mk(1'b1, 2'd2, 1'b0, 32'd4092,     32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1);
    vecs[13] = mk(1'b0, 2'd2, 1'b0, 32'd4092,     32'h0,        32'hDEADBEEF, 1'b0, 2, 0);
    vecs[14] = mk(1'b0, 2'd1, 1'b0, 32'd4095,     32'h0,        32'h00000000, 1'b1, 1, 0);

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      nm = $sformatf("v%0d", i);
      do_req(nm, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
             rd, er, lat, wec);
      chk({nm, "_rdata"}, rd,          vecs[i].exp_rdata);
      chk({nm, "_err"},   32'(er),     32'(vecs[i].exp_err));
      chk({nm, "_lat"},   32'(lat),    32'(vecs[i].exp_lat));
      chk({nm, "_wecnt"}, 32'(wec),    32'(vecs[i].exp_we));
    end

    // Misaligned word store: four byte cycles, little-endian, low byte first.
    do_req("sw5", 1'b1, 2'd2, 1'b0, 32'd5, 32'hAABBCCDD, rd, er, lat, wec);
    chk("sw5_lat",   32'(lat), 32'd5);
    chk("sw5_wecnt", 32'(wec), 32'd4);
    exp_bytes[0] = 8'hDD; exp_bytes[1] = 8'hCC; exp_bytes[2] = 8'hBB; exp_bytes[3] = 8'hAA;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("sw5_c%0d_addr", c), log_addr[c], 32'(5 + c - 1));
      chk($sformatf("sw5_c%0d_din", c),  log_din[c],  {24'd0, exp_bytes[c-1]});
      chk($sformatf("sw5_c%0d_ctrl", c), 32'(log_ctrl[c]), 32'd0);
    end
    do_req("lw5", 1'b0, 2'd2, 1'b0, 32'd5, 32'h0, rd, er, lat, wec);
    chk("lw5_rdata", rd, 32'hAABBCCDD);
    chk("lw5_err",   32'(er), 32'd0);
    chk("lw5_lat",   32'(lat), 32'd5);

    // Misaligned half load across bytes 7/8.
    do_req("sb7", 1'b1, 2'd0, 1'b0, 32'd7, 32'h000000FF, rd, er, lat, wec);
    do_req("sb8", 1'b1, 2'd0, 1'b0, 32'd8, 32'h00000080, rd, er, lat, wec);
    do_req("lh7", 1'b0, 2'd1, 1'b0, 32'd7, 32'h0, rd, er, lat, wec);
    chk("lh7_rdata", rd, 32'hFFFF80FF);
    chk("lh7_lat",   32'(lat), 32'd3);
    chk("lh7_wecnt", 32'(wec), 32'd0);
    do_req("lhu7", 1'b0, 2'd1, 1'b1, 32'd7, 32'h0, rd, er, lat, wec);
    chk("lhu7_rdata", rd, 32'h000080FF);

    // Reset during SPLIT k=1 of a word store at addr 1.
    do_req("sw0", 1'b1, 2'd2, 1'b0, 32'd0, 32'h44332211, rd, er, lat, wec);
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'd1; req_wdata = 32'hA1B2C3D4; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rs_k0_addr", mem_address, 32'd1);
    @(posedge clk); #1;
    chk("rs_k1_addr", mem_address, 32'd2);
    chk("rs_k1_we",   32'(mem_we), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rs_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (rsp_valid) rsp_seen++;
      @(posedge clk); #1;
    end
    chk("rs_no_rsp", 32'(rsp_seen), 32'd0);
    chk("rs_byte1", 32'(ram[1]), 32'h000000D4);
    chk("rs_byte2", 32'(ram[2]), 32'h00000033);
    chk("rs_byte3", 32'(ram[3]), 32'h00000044);
    chk("rs_byte4", 32'(ram[4]), 32'h00000078);
    do_req("rs_lw0", 1'b0, 2'd2, 1'b0, 32'd0, 32'h0, rd, er, lat, wec);
    chk("rs_lw0_rdata", rd, 32'h4433D411);
    chk("rs_lw0_lat",   32'(lat), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
